dmem_arbiter: RTL and testbench

Arbitrates the single-port synchronous data memory between two requesters: the processor's memory stage and the VGA pixel fetcher. The processor normally has priority. A bounded-starvation counter guarantees the video fetcher a slot, and `cpu_stall` holds the pipeline whenever the processor is refused. The block sits between the processor's dmem outputs (`address_dmem`/`data`/`wren`/`q_dmem`) and the dmem instance in the wrapper.

---
 rtl/dmem_arbiter.sv | 104 ++++++++++
 tb/tb_dmem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port synchronous data memory between the
// processor memory stage and the VGA pixel fetcher. The processor normally
// wins; a saturating starvation counter forces a video slot after
// STARVE_LIMIT consecutive refusals. Read data returns one cycle after the
// grant and is steered to whichever requester owned the previous cycle.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clock,
  input  logic        reset,
  // processor side
  input  logic        cpu_req,
  input  logic        cpu_wren,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  // video fetcher side
  input  logic        vid_req,
  input  logic [31:0] vid_addr,
  output logic        vid_grant,
  output logic        vid_rvalid,
  output logic [31:0] vid_rdata,
  // data memory side
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wren,
  input  logic [31:0] mem_q
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             cpu_rd_q;
  logic             cpu_rd_d;
  logic             vid_rd_q;
  logic             vid_rd_d;
  logic             vid_win;
  logic             cpu_grant;
  logic             starved;

  // Grant decision: video takes the slot when the CPU is idle or when the
  // video request has been refused STARVE_LIMIT times in a row. Reset
  // forces every grant low so nothing reaches the memory mid-reset.
  always_comb begin
    starved   = (starve_cnt_q == LIMIT);
    vid_win   = 1'b0;
    cpu_grant = 1'b0;
    if (!reset) begin
      vid_win   = vid_req & (~cpu_req | starved);
      cpu_grant = cpu_req & ~vid_win;
    end
  end

  // Memory-side mux; the CPU address is the idle default so a pending
  // store's address is already on the bus when it is granted.
  always_comb begin
    mem_addr  = vid_win ? vid_addr : cpu_addr;
    mem_wdata = cpu_wdata;
    mem_wren  = cpu_grant & cpu_wren;
    vid_grant = vid_win;
    cpu_stall = cpu_req & vid_win;
  end

  // Next-state for the starvation counter and the read-return tags. The
  // counter only runs while video is waiting and losing; it saturates so a
  // long CPU burst cannot wrap it back below the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (vid_win || !vid_req) begin
      starve_cnt_d = '0;
    end else if (!starved) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
    cpu_rd_d = cpu_grant & ~cpu_wren;
    vid_rd_d = vid_win;
  end

  // State update; reset clears the counter and drops any in-flight read tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
      cpu_rd_q     <= 1'b0;
      vid_rd_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      cpu_rd_q     <= cpu_rd_d;
      vid_rd_q     <= vid_rd_d;
    end
  end

  // Read return: dmem output is shared, each side sees it only on its own
  // valid cycle.
  always_comb begin
    cpu_rvalid = cpu_rd_q;
    vid_rvalid = vid_rd_q;
    cpu_rdata  = cpu_rd_q ? mem_q : 32'h0;
    vid_rdata  = vid_rd_q ? mem_q : 32'h0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural dmem model.
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_req;
  logic        cpu_wren;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        vid_req;
  logic [31:0] vid_addr;
  logic        vid_grant;
  logic        vid_rvalid;
  logic [31:0] vid_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wren;
  logic [31:0] mem_q;

  logic [31:0] mem [0:1023];

  int n_chk;
  int n_fail;

  dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_wren   (cpu_wren),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_grant  (vid_grant),
    .vid_rvalid (vid_rvalid),
    .vid_rdata  (vid_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous single-port memory, one-cycle read latency.
  always @(posedge clock) begin
    if (mem_wren) mem[mem_addr[11:2]] <= mem_wdata;
    mem_q <= mem[mem_addr[11:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5000000 | i;
    mem[32'h10 >> 2]  = 32'hDEADBEEF;
    mem[32'h400 >> 2] = 32'hCAFE0400;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    vid_req = 1'b0; vid_addr = 32'h0;
    cyc();

    // Reset: requests present but every grant forced low.
    cpu_req = 1'b1; cpu_wren = 1'b1; vid_req = 1'b1; vid_addr = 32'h400;
    @(negedge clock);
    check("rst_vid_grant", {31'b0, vid_grant}, 32'd0);
    check("rst_mem_wren", {31'b0, mem_wren}, 32'd0);
    check("rst_cpu_stall", {31'b0, cpu_stall}, 32'd0);
    check("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    check("rst_vid_rvalid", {31'b0, vid_rvalid}, 32'd0);
    cyc();
    @(negedge clock);
    check("rst2_vid_rvalid", {31'b0, vid_rvalid}, 32'd0);
    cyc();

    // Idle CPU: video granted in the same cycle.
    reset = 1'b0; cpu_req = 1'b0; cpu_wren = 1'b0;
    @(negedge clock);
    check("idle_vid_grant", {31'b0, vid_grant}, 32'd1);
    check("idle_mem_addr", mem_addr, 32'h400);
    check("idle_cpu_stall", {31'b0, cpu_stall}, 32'd0);
    cyc();
    vid_req = 1'b0;
    @(negedge clock);
    check("idle_vid_rvalid", {31'b0, vid_rvalid}, 32'd1);
    check("idle_vid_rdata", vid_rdata, 32'hCAFE0400);
    check("idle_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    check("idle_vid_grant_off", {31'b0, vid_grant}, 32'd0);
    cyc();

    // CPU load alone.
    cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 32'h10;
    @(negedge clock);
    check("ld_stall", {31'b0, cpu_stall}, 32'd0);
    check("ld_mem_addr", mem_addr, 32'h10);
    check("ld_mem_wren", {31'b0, mem_wren}, 32'd0);
    cyc();
    cpu_req = 1'b0;
    @(negedge clock);
    check("ld_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd1);
    check("ld_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    check("ld_vid_rvalid", {31'b0, vid_rvalid}, 32'd0);
    cyc();

    // CPU store, then load back.
    cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234;
    @(negedge clock);
    check("st_mem_wren", {31'b0, mem_wren}, 32'd1);
    check("st_mem_addr", mem_addr, 32'h20);
    check("st_mem_wdata", mem_wdata, 32'h1234);
    check("st_stall", {31'b0, cpu_stall}, 32'd0);
    cyc();
    cpu_wren = 1'b0;
    @(negedge clock);
    check("st_no_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    cyc();
    cpu_req = 1'b0;
    @(negedge clock);
    check("st_rb_rvalid", {31'b0, cpu_rvalid}, 32'd1);
    check("st_rb_rdata", cpu_rdata, 32'h1234);
    cyc();

    // Contention: 4 CPU grants then 1 video grant, period 5.
    cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 32'h10;
    vid_req = 1'b1; vid_addr = 32'h400;
    for (int i = 0; i < 10; i++) begin
      logic v;
      v = (i % 5) == 4;
      @(negedge clock);
      check($sformatf("cont%0d_vid_grant", i), {31'b0, vid_grant}, {31'b0, v});
      check($sformatf("cont%0d_cpu_stall", i), {31'b0, cpu_stall}, {31'b0, v});
      check($sformatf("cont%0d_mem_addr", i), mem_addr, v ? 32'h400 : 32'h10);
      if (i > 0) begin
        check($sformatf("cont%0d_vid_rvalid", i), {31'b0, vid_rvalid}, {31'b0, (i % 5) == 0});
        check($sformatf("cont%0d_cpu_rvalid", i), {31'b0, cpu_rvalid}, {31'b0, (i % 5) != 0});
        if ((i % 5) == 0) check($sformatf("cont%0d_vid_rdata", i), vid_rdata, 32'hCAFE0400);
        else              check($sformatf("cont%0d_cpu_rdata", i), cpu_rdata, 32'hDEADBEEF);
      end
      cyc();
    end

    // Reset while the counter sits at 3.
    for (int i = 0; i < 3; i++) cyc();
    reset = 1'b1;
    @(negedge clock);
    check("midrst_vid_grant", {31'b0, vid_grant}, 32'd0);
    check("midrst_cpu_stall", {31'b0, cpu_stall}, 32'd0);
    cyc();
    reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      check($sformatf("post_rst%0d_vid_grant", j), {31'b0, vid_grant}, {31'b0, j == 4});
      if (j == 0) begin
        check("post_rst_vid_rvalid", {31'b0, vid_rvalid}, 32'd0);
        check("post_rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
      end
      cyc();
    end

    // Reset on the cycle video would have won: its read tag must never show.
    for (int i = 0; i < 4; i++) cyc();
    reset = 1'b1;
    @(negedge clock);
    check("vwin_rst_vid_grant", {31'b0, vid_grant}, 32'd0);
    cyc();
    reset = 1'b0;
    @(negedge clock);
    check("vwin_rst_vid_rvalid", {31'b0, vid_rvalid}, 32'd0);
    check("vwin_rst_cpu_grant", {31'b0, cpu_stall}, 32'd0);
    cyc();

    // Video withdrawal at count 3 restarts the count.
    cyc(); cyc();
    vid_req = 1'b0;
    @(negedge clock);
    check("wd_vid_grant", {31'b0, vid_grant}, 32'd0);
    check("wd_cpu_stall", {31'b0, cpu_stall}, 32'd0);
    cyc();
    vid_req = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j == 4) begin
        cpu_wren = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h5A5A;
      end
      @(negedge clock);
      check($sformatf("wd%0d_vid_grant", j), {31'b0, vid_grant}, {31'b0, j == 4});
      if (j == 4) check("wd_store_blocked", {31'b0, mem_wren}, 32'd0);
      cyc();
    end

    // The stalled store issues next cycle with its data held.
    @(negedge clock);
    check("st_late_wren", {31'b0, mem_wren}, 32'd1);
    check("st_late_addr", mem_addr, 32'h30);
    check("st_late_wdata", mem_wdata, 32'h5A5A);
    check("st_late_vid_rvalid", {31'b0, vid_rvalid}, 32'd1);
    cyc();
    cpu_req = 1'b0; vid_req = 1'b0; cpu_wren = 1'b0;
    cyc();
    check("st_late_mem", mem[32'h30 >> 2], 32'h5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
